// File: rtl/alt_dfe_rmw_master.sv
// Avalon-MM read-modify-write master for DFE reconfiguration via the AVMM-to-DPRIO gasket.
// Optional post-write readback check enabled by defining ALT_DFE_RMW_VERIFY_EN.
module alt_dfe_rmw_master #(
    parameter int AVMM_ADDR_WIDTH = 16,
    parameter int AVMM_DATA_WIDTH = 16,
    parameter int TIMEOUT_CYCLES  = 1023
) (
    input  logic                       i_avmm_clk,
    input  logic                       i_resetn,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [AVMM_ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [AVMM_DATA_WIDTH-1:0] i_cmd_mask,
    input  logic [AVMM_DATA_WIDTH-1:0] i_cmd_data,
    output logic                       o_done,
    output logic [1:0]                 o_status,
    output logic [AVMM_DATA_WIDTH-1:0] o_rdata,
    output logic [AVMM_ADDR_WIDTH-1:0] o_avmm_address,
    output logic                       o_avmm_read,
    output logic                       o_avmm_write,
    output logic [AVMM_DATA_WIDTH-1:0] o_avmm_writedata,
    input  logic [AVMM_DATA_WIDTH-1:0] i_avmm_readdata,
    input  logic                       i_avmm_waitrequest
);

    localparam logic [1:0]  ST_OK       = 2'd0;
    localparam logic [1:0]  ST_TIMEOUT  = 2'd1;
    localparam logic [1:0]  ST_MISMATCH = 2'd2;
    localparam logic [16:0] TMO_LIM     = 17'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_VFY, S_DONE} state_t;

    typedef struct packed {
        logic [AVMM_DATA_WIDTH-1:0] mask;
        logic [AVMM_DATA_WIDTH-1:0] data;
    } cmd_t;

    state_t                     state, state_nxt;
    cmd_t                       cmd, cmd_nxt;
    logic [15:0]                tmo_cnt, tmo_cnt_nxt;
    logic                       rd_nxt, wr_nxt;
    logic [AVMM_ADDR_WIDTH-1:0] addr_nxt;
    logic [AVMM_DATA_WIDTH-1:0] wdata_nxt, rdata_nxt;
    logic [1:0]                 status_nxt;
    logic                       accept, tmo_hit;

    assign o_cmd_ready = (state == S_IDLE);
    assign o_done      = (state == S_DONE);
    assign accept      = i_cmd_valid && o_cmd_ready;
    // Abort on the edge that closes the TIMEOUT_CYCLES-th stalled cycle of a phase.
    assign tmo_hit     = (TIMEOUT_CYCLES != 0) && i_avmm_waitrequest &&
                         (({1'b0, tmo_cnt} + 17'd1) == TMO_LIM);

    always_ff @(posedge i_avmm_clk) begin
        if (!i_resetn) begin
            state            <= S_IDLE;
            cmd              <= '0;
            tmo_cnt          <= '0;
            o_avmm_read      <= 1'b0;
            o_avmm_write     <= 1'b0;
            o_avmm_address   <= '0;
            o_avmm_writedata <= '0;
            o_rdata          <= '0;
            o_status         <= ST_OK;
        end else begin
            state            <= state_nxt;
            cmd              <= cmd_nxt;
            tmo_cnt          <= tmo_cnt_nxt;
            o_avmm_read      <= rd_nxt;
            o_avmm_write     <= wr_nxt;
            o_avmm_address   <= addr_nxt;
            o_avmm_writedata <= wdata_nxt;
            o_rdata          <= rdata_nxt;
            o_status         <= status_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_nxt     = cmd;
        tmo_cnt_nxt = tmo_cnt;
        rd_nxt      = o_avmm_read;
        wr_nxt      = o_avmm_write;
        addr_nxt    = o_avmm_address;
        wdata_nxt   = o_avmm_writedata;
        rdata_nxt   = o_rdata;
        status_nxt  = o_status;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    cmd_nxt.mask = i_cmd_mask;
                    cmd_nxt.data = i_cmd_data;
                    addr_nxt     = i_cmd_addr;
                    status_nxt   = ST_OK;
                    tmo_cnt_nxt  = '0;
                    // Full-width update needs no read: write straight away.
                    if (i_cmd_mask == '1) begin
                        wdata_nxt = i_cmd_data;
                        rdata_nxt = '0;
                        wr_nxt    = 1'b1;
                        state_nxt = S_WR;
                    end else begin
                        rd_nxt    = 1'b1;
                        state_nxt = S_RD;
                    end
                end
            end

            S_RD: begin
                if (!i_avmm_waitrequest) begin
                    rdata_nxt   = i_avmm_readdata;
                    rd_nxt      = 1'b0;
                    tmo_cnt_nxt = '0;
                    if (cmd.mask == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        wdata_nxt = (i_avmm_readdata & ~cmd.mask) | (cmd.data & cmd.mask);
                        wr_nxt    = 1'b1;
                        state_nxt = S_WR;
                    end
                end else if (tmo_hit) begin
                    rd_nxt     = 1'b0;
                    status_nxt = ST_TIMEOUT;
                    state_nxt  = S_DONE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 16'd1;
                end
            end

            S_WR: begin
                if (!i_avmm_waitrequest) begin
                    wr_nxt      = 1'b0;
                    tmo_cnt_nxt = '0;
`ifdef ALT_DFE_RMW_VERIFY_EN
                    rd_nxt      = 1'b1;
                    state_nxt   = S_VFY;
`else
                    state_nxt   = S_DONE;
`endif
                end else if (tmo_hit) begin
                    wr_nxt     = 1'b0;
                    status_nxt = ST_TIMEOUT;
                    state_nxt  = S_DONE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 16'd1;
                end
            end

`ifdef ALT_DFE_RMW_VERIFY_EN
            S_VFY: begin
                if (!i_avmm_waitrequest) begin
                    rd_nxt     = 1'b0;
                    status_nxt = ((i_avmm_readdata & cmd.mask) != (cmd.data & cmd.mask))
                                 ? ST_MISMATCH : ST_OK;
                    state_nxt  = S_DONE;
                end else if (tmo_hit) begin
                    rd_nxt     = 1'b0;
                    status_nxt = ST_TIMEOUT;
                    state_nxt  = S_DONE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 16'd1;
                end
            end
`endif

            S_DONE: state_nxt = S_IDLE;

            default: begin
                rd_nxt    = 1'b0;
                wr_nxt    = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alt_dfe_rmw_master.sv
// Directed bench for alt_dfe_rmw_master with a stall-programmable AVMM slave model.
module tb_alt_dfe_rmw_master;

    localparam int AW = 16;
    localparam int DW = 16;
`ifdef ALT_DFE_RMW_VERIFY_EN
    localparam int VFY = 1;
`else
    localparam int VFY = 0;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_mask, cmd_data;
    logic          done;
    logic [1:0]    status;
    logic [DW-1:0] rdata;
    logic [AW-1:0] avmm_address;
    logic          avmm_read, avmm_write;
    logic [DW-1:0] avmm_writedata, avmm_readdata;
    logic          avmm_waitrequest;

    always #5 clk = ~clk;

    alt_dfe_rmw_master #(
        .AVMM_ADDR_WIDTH(AW), .AVMM_DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .i_avmm_clk        (clk),
        .i_resetn          (resetn),
        .i_cmd_valid       (cmd_valid),
        .o_cmd_ready       (cmd_ready),
        .i_cmd_addr        (cmd_addr),
        .i_cmd_mask        (cmd_mask),
        .i_cmd_data        (cmd_data),
        .o_done            (done),
        .o_status          (status),
        .o_rdata           (rdata),
        .o_avmm_address    (avmm_address),
        .o_avmm_read       (avmm_read),
        .o_avmm_write      (avmm_write),
        .o_avmm_writedata  (avmm_writedata),
        .i_avmm_readdata   (avmm_readdata),
        .i_avmm_waitrequest(avmm_waitrequest)
    );

    // Slave model: each phase stalls for stall_rd / stall_wr cycles, then completes.
    int            stall_rd = 0, stall_wr = 0;
    logic [DW-1:0] rd_val = '0, vfy_val = '0;
    int            rd_base = 0;
    int            st_cnt = 0, rd_cnt = 0, wr_cnt = 0, rdcyc = 0, wrcyc = 0;
    int            both_cnt = 0, unstable = 0;
    logic [DW-1:0] last_wdata = '0;
    logic          pend = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_wdata = '0;

    assign avmm_waitrequest = avmm_read  ? (st_cnt < stall_rd) :
                              avmm_write ? (st_cnt < stall_wr) : 1'b0;
    assign avmm_readdata    = (rd_cnt == rd_base) ? rd_val : vfy_val;

    always @(posedge clk) begin
        if (avmm_read && avmm_write) both_cnt <= both_cnt + 1;
        if (avmm_read)  rdcyc <= rdcyc + 1;
        if (avmm_write) wrcyc <= wrcyc + 1;
        if ((avmm_read || avmm_write) && avmm_waitrequest) st_cnt <= st_cnt + 1;
        else                                               st_cnt <= 0;
        if (avmm_read && !avmm_waitrequest) rd_cnt <= rd_cnt + 1;
        if (avmm_write && !avmm_waitrequest) begin
            wr_cnt     <= wr_cnt + 1;
            last_wdata <= avmm_writedata;
        end
        if (pend && (avmm_read != p_rd || avmm_write != p_wr ||
                     avmm_address != p_addr || avmm_writedata != p_wdata))
            unstable <= unstable + 1;
        pend    <= (avmm_read || avmm_write) && avmm_waitrequest;
        p_rd    <= avmm_read;
        p_wr    <= avmm_write;
        p_addr  <= avmm_address;
        p_wdata <= avmm_writedata;
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept happens on the edge closing cycle T; lat = cycles after T until o_done.
    task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] m,
                         input logic [DW-1:0] d, output int lat);
        @(negedge clk);
        rd_base   = rd_cnt;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_mask  = m;
        cmd_data  = d;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_addr = '1; cmd_mask = '1; cmd_data = '1;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    int lat, r0, w0, rc0, wc0, u0, dones;
    logic seen;

    initial begin
        resetn = 1'b0; cmd_valid = 1'b0;
        cmd_addr = '0; cmd_mask = '0; cmd_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",  cmd_ready, 1);
        chk("rst_done",   done, 0);
        chk("rst_rw",     {avmm_read, avmm_write}, 0);
        chk("rst_status", status, 0);
        chk("rst_rdata",  rdata, 0);
        chk("rst_addr",   avmm_address, 0);
        chk("rst_wdata",  avmm_writedata, 0);
        resetn = 1'b1;

        // 1: basic merge, zero-wait slave
        rd_val = 16'hABCD; vfy_val = 16'hAB5D;
        w0 = wr_cnt;
        issue(16'h0123, 16'h00F0, 16'h0050, lat);
        chk("t1_lat",    lat, 3 + VFY);
        chk("t1_status", status, 0);
        chk("t1_rdata",  rdata, 16'hABCD);
        chk("t1_wdata",  last_wdata, 16'hAB5D);
        chk("t1_nwr",    wr_cnt - w0, 1);
        chk("t1_addr",   avmm_address, 16'h0123);

        // 2: three stall cycles per phase
        stall_rd = 3; stall_wr = 3;
        w0 = wr_cnt; rc0 = rdcyc; wc0 = wrcyc; u0 = unstable;
        issue(16'h0456, 16'h00F0, 16'h0050, lat);
        chk("t2_lat",      lat, 9 + 4 * VFY);
        chk("t2_status",   status, 0);
        chk("t2_wdata",    last_wdata, 16'hAB5D);
        chk("t2_nwr",      wr_cnt - w0, 1);
        chk("t2_rdcyc",    rdcyc - rc0, 4 + 4 * VFY);
        chk("t2_wrcyc",    wrcyc - wc0, 4);
        chk("t2_unstable", unstable - u0, 0);

        // 3a: full mask, write only
        stall_rd = 0; stall_wr = 0;
        rd_val = 16'h1234; vfy_val = 16'h1234;
        r0 = rd_cnt; w0 = wr_cnt;
        issue(16'h0010, 16'hFFFF, 16'h1234, lat);
        chk("t3a_lat",    lat, 2 + VFY);
        chk("t3a_nrd",    rd_cnt - r0, VFY);
        chk("t3a_nwr",    wr_cnt - w0, 1);
        chk("t3a_wdata",  last_wdata, 16'h1234);
        chk("t3a_rdata",  rdata, 0);
        chk("t3a_status", status, 0);

        // 3b: empty mask, pure read
        rd_val = 16'hABCD;
        r0 = rd_cnt; w0 = wr_cnt;
        issue(16'h0020, 16'h0000, 16'hFFFF, lat);
        chk("t3b_lat",   lat, 2);
        chk("t3b_nrd",   rd_cnt - r0, 1);
        chk("t3b_nwr",   wr_cnt - w0, 0);
        chk("t3b_rdata", rdata, 16'hABCD);

        // 4: read stalled forever -> timeout after 8 stall cycles
        stall_rd = 1000;
        w0 = wr_cnt; rc0 = rdcyc;
        issue(16'h0030, 16'h00F0, 16'h0050, lat);
        chk("t4_lat",      lat, 9);
        chk("t4_status",   status, 1);
        chk("t4_rdcyc",    rdcyc - rc0, 8);
        chk("t4_nwr",      wr_cnt - w0, 0);
        chk("t4_ready_dn", cmd_ready, 0);
        @(negedge clk);
        chk("t4_ready",    cmd_ready, 1);
        chk("t4_rw",       {avmm_read, avmm_write}, 0);

        // 5: reset during a write stall
        stall_rd = 0; stall_wr = 5;
        w0 = wr_cnt;
        @(negedge clk);
        rd_base = rd_cnt;
        cmd_valid = 1'b1; cmd_addr = 16'h0040; cmd_mask = 16'h00F0; cmd_data = 16'h0050;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = avmm_write;
        end
        chk("t5_wr_seen", seen, 1);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_rw",    {avmm_read, avmm_write}, 0);
        chk("t5_ready", cmd_ready, 1);
        chk("t5_done",  done, 0);
        @(negedge clk);
        resetn = 1'b1;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("t5_nodone", dones, 0);
        chk("t5_nwr",    wr_cnt - w0, 0);
        chk("t5_idle",   cmd_ready, 1);
        stall_wr = 0;

`ifdef ALT_DFE_RMW_VERIFY_EN
        // 6: readback disagrees with the written field
        rd_val = 16'hABCD; vfy_val = 16'hAB0D;
        issue(16'h0123, 16'h00F0, 16'h0050, lat);
        chk("t6_lat",    lat, 4);
        chk("t6_status", status, 2);
        chk("t6_rdata",  rdata, 16'hABCD);
`endif

        chk("never_rw_both", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
